// File: rtl/total_alu.sv
// 32-bit MIPS-style ALU with a sequential restoring unsigned divider feeding HI/LO.
// Optional build macro TOTAL_ALU_DIVZERO_FAST_EN: divide by zero completes on the start edge.
module total_alu (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [5:0]  Signal,
    output logic [31:0] Output
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned FUNCT_W = 6;

    localparam logic [FUNCT_W-1:0] OP_SLL  = FUNCT_W'(0);
    localparam logic [FUNCT_W-1:0] OP_MFHI = FUNCT_W'(16);
    localparam logic [FUNCT_W-1:0] OP_MFLO = FUNCT_W'(18);
    localparam logic [FUNCT_W-1:0] OP_DIVU = FUNCT_W'(27);
    localparam logic [FUNCT_W-1:0] OP_ADD  = FUNCT_W'(32);
    localparam logic [FUNCT_W-1:0] OP_SUB  = FUNCT_W'(34);
    localparam logic [FUNCT_W-1:0] OP_AND  = FUNCT_W'(36);
    localparam logic [FUNCT_W-1:0] OP_OR   = FUNCT_W'(37);
    localparam logic [FUNCT_W-1:0] OP_SLT  = FUNCT_W'(42);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0]  rem_q, rem_d, quo_q, quo_d, div_q, div_d;
    logic [FUNCT_W-1:0] prev_sig_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               busy_q, busy_d;
    logic               start_c;
    logic [DATA_W:0]    rem_sh_c;

    // Combinational result mux
    always_comb begin
        Output = '0;
        case (Signal)
            OP_AND:  Output = dataA & dataB;
            OP_OR:   Output = dataA | dataB;
            OP_ADD:  Output = dataA + dataB;
            OP_SUB:  Output = dataA - dataB;
            OP_SLT:  Output = DATA_W'($signed(dataA) < $signed(dataB));
            OP_SLL:  Output = dataA << dataB[4:0];
            OP_MFHI: Output = hi_q;
            OP_MFLO: Output = lo_q;
            default: Output = '0;
        endcase
    end

    // Divider next-state: one restoring shift-subtract step per cycle while busy
    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        count_d  = count_q;
        busy_d   = busy_q;
        start_c  = (Signal == OP_DIVU) && (prev_sig_q != OP_DIVU) && !busy_q;
        rem_sh_c = {rem_q, quo_q[DATA_W-1]};

        if (busy_q) begin
            if (rem_sh_c >= {1'b0, div_q}) begin
                rem_d = DATA_W'(rem_sh_c - {1'b0, div_q});
                quo_d = {quo_q[DATA_W-2:0], 1'b1};
            end else begin
                rem_d = rem_sh_c[DATA_W-1:0];
                quo_d = {quo_q[DATA_W-2:0], 1'b0};
            end
            count_d = count_q + CNT_W'(1);
            if (count_q == LAST_ITER) begin
                hi_d    = rem_d;
                lo_d    = quo_d;
                busy_d  = 1'b0;
                count_d = '0;
            end
        end else if (start_c) begin
`ifdef TOTAL_ALU_DIVZERO_FAST_EN
            if (dataB == '0) begin
                hi_d = dataA;
                lo_d = '1;
            end else begin
                rem_d   = '0;
                quo_d   = dataA;
                div_d   = dataB;
                count_d = '0;
                busy_d  = 1'b1;
            end
`else
            rem_d   = '0;
            quo_d   = dataA;
            div_d   = dataB;
            count_d = '0;
            busy_d  = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q       <= '0;
            lo_q       <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            div_q      <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            prev_sig_q <= '0;
        end else begin
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            div_q      <= div_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            prev_sig_q <= Signal;
        end
    end

endmodule

// File: tb/tb_total_alu.sv
// Scoreboard bench for total_alu: expected results queued at drive time, checked after the edge.
module tb_total_alu;

    logic        clk;
    logic        reset;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic [31:0] Output;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    total_alu dut (
        .clk    (clk),
        .reset  (reset),
        .dataA  (dataA),
        .dataB  (dataB),
        .Signal (Signal),
        .Output (Output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one op, let one rising edge pass, then compare at the falling edge
    task automatic apply(input string tag, input logic [5:0] sig,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        exp_t e;
        Signal = sig;
        dataA  = a;
        dataB  = b;
        e.tag  = tag;
        e.val  = exp;
        exp_q.push_back(e);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, Output, e.val);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset  = 1'b1;
        Signal = 6'd16;
        dataA  = '0;
        dataB  = '0;
        @(negedge clk);
        reset = 1'b0;

        apply("rst_mfhi", 6'd16, 32'd0, 32'd0, 32'd0);
        apply("rst_mflo", 6'd18, 32'd0, 32'd0, 32'd0);

        apply("and",      6'd36, 32'd12, 32'd10, 32'd8);
        apply("or",       6'd37, 32'd12, 32'd10, 32'd14);
        apply("add",      6'd32, 32'd7, 32'd5, 32'd12);
        apply("add_wrap", 6'd32, 32'hFFFF_FFFF, 32'd1, 32'd0);
        apply("sub_neg",  6'd34, 32'd5, 32'd7, 32'hFFFF_FFFE);
        apply("slt_t",    6'd42, 32'hFFFF_FFFF, 32'd1, 32'd1);
        apply("slt_f",    6'd42, 32'd1, 32'hFFFF_FFFF, 32'd0);
        apply("sll",      6'd0, 32'd3, 32'd4, 32'd48);
        apply("sll_mask", 6'd0, 32'd1, 32'd33, 32'd2);
        apply("bad_op",   6'd5, 32'd3, 32'd4, 32'd0);

        // Plain divide, held code
        apply("divu_out", 6'd27, 32'd100, 32'd7, 32'd0);
        hold(35);
        apply("div1_hi", 6'd16, 32'd0, 32'd0, 32'd2);
        apply("div1_lo", 6'd18, 32'd0, 32'd0, 32'd14);

        // Second divide; old HI/LO visible while busy, re-request ignored
        apply("divu2",      6'd27, 32'hFFFF_FFFF, 32'd16, 32'd0);
        apply("busy_lo",    6'd18, 32'd0, 32'd0, 32'd14);
        apply("busy_hi",    6'd16, 32'd0, 32'd0, 32'd2);
        apply("divu2_req",  6'd27, 32'd1000, 32'd3, 32'd0);
        hold(35);
        apply("div2_hi", 6'd16, 32'd0, 32'd0, 32'd15);
        apply("div2_lo", 6'd18, 32'd0, 32'd0, 32'd268435455);

        // Divide by zero
        apply("divz", 6'd27, 32'd9, 32'd0, 32'd0);
        hold(35);
        apply("divz_hi", 6'd16, 32'd0, 32'd0, 32'd9);
        apply("divz_lo", 6'd18, 32'd0, 32'd0, 32'hFFFF_FFFF);

        // Reset mid-divide aborts with no writeback
        apply("div3", 6'd27, 32'd50, 32'd3, 32'd0);
        hold(9);
        Signal = 6'd16;
        reset  = 1'b1;
        #1;
        check("async_rst_hi", Output, 32'd0);
        apply("rst_mid_hi", 6'd16, 32'd0, 32'd0, 32'd0);
        apply("rst_mid_lo", 6'd18, 32'd0, 32'd0, 32'd0);
        reset = 1'b0;
        hold(40);
        apply("no_wb_lo", 6'd18, 32'd0, 32'd0, 32'd0);
        apply("no_wb_hi", 6'd16, 32'd0, 32'd0, 32'd0);

        // Signal changes mid-divide; latched operands still used
        apply("div4",      6'd27, 32'd50, 32'd3, 32'd0);
        apply("mid_add",   6'd32, 32'd7, 32'd5, 32'd12);
        apply("mid_req",   6'd27, 32'd9, 32'd0, 32'd0);
        apply("mid_sub",   6'd34, 32'd9, 32'd4, 32'd5);
        hold(35);
        apply("div4_hi", 6'd16, 32'd0, 32'd0, 32'd2);
        apply("div4_lo", 6'd18, 32'd0, 32'd0, 32'd16);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
